// File: rtl/chess_sprite_addr_ctrl_if.sv
`default_nettype none
// ============================================================================
// chess_sprite_addr_ctrl_if : pixel, board-write and sprite-address bundle
// Revision: 1.0
// ============================================================================
interface chess_sprite_addr_ctrl_if;
  logic        pix_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        wr_en;
  logic [5:0]  wr_sq;
  logic [3:0]  wr_piece;
  logic        wr_ack;
  logic        load_req;
  logic        busy;
  logic [5:0]  rd_sq;
  logic [3:0]  rd_piece;
  logic [16:0] sprite_addr;
  logic        addr_valid;
  logic        in_board;
  logic        in_board_ram;

  modport master (
    output pix_en, DrawX, DrawY, wr_en, wr_sq, wr_piece, load_req, rd_sq,
    input  wr_ack, busy, rd_piece, sprite_addr, addr_valid, in_board, in_board_ram
  );

  modport slave (
    input  pix_en, DrawX, DrawY, wr_en, wr_sq, wr_piece, load_req, rd_sq,
    output wr_ack, busy, rd_piece, sprite_addr, addr_valid, in_board, in_board_ram
  );
endinterface
`default_nettype wire

// File: rtl/chess_sprite_addr_ctrl.sv
`default_nettype none
// ============================================================================
// chess_sprite_addr_ctrl : chess board state + VGA pixel to sprite ROM address
// Revision: 1.0
// ============================================================================
module chess_sprite_addr_ctrl #(
  parameter int BOARD_X0 = 80,
  parameter int BOARD_Y0 = 0,
  parameter int SQ_PIX   = 60
) (
  input logic                     CLK,
  input logic                     RESET,
  chess_sprite_addr_ctrl_if.slave bus
);

  localparam logic [10:0] X_LO = 11'(BOARD_X0);
  localparam logic [10:0] X_HI = 11'(BOARD_X0 + 8 * SQ_PIX);
  localparam logic [10:0] Y_LO = 11'(BOARD_Y0);
  localparam logic [10:0] Y_HI = 11'(BOARD_Y0 + 8 * SQ_PIX);

  typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_IDLE = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  board_q [64];
  logic        wr_ack_q;
  logic        w_busy;
  logic        w_we;
  logic [5:0]  w_wsq;
  logic [3:0]  w_wdata;

  // Back rank for black; white rank 1 is the same types with the white bit set.
  function automatic logic [3:0] init_piece(input logic [5:0] idx);
    logic [3:0] back;
    case (idx[2:0])
      3'd0, 3'd7: back = 4'h4;
      3'd1, 3'd6: back = 4'h3;
      3'd2, 3'd5: back = 4'h2;
      3'd3:       back = 4'h5;
      default:    back = 4'h6;
    endcase
    case (idx[5:3])
      3'd0:    init_piece = back;
      3'd1:    init_piece = 4'h1;
      3'd6:    init_piece = 4'h9;
      3'd7:    init_piece = {1'b1, back[2:0]};
      default: init_piece = 4'h0;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_LOAD;
      idx_q    <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ack_q <= bus.wr_en && (state_q == ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_busy  = 1'b0;
    w_we    = 1'b0;
    w_wsq   = bus.wr_sq;
    w_wdata = bus.wr_piece;
    case (state_q)
      ST_LOAD: begin
        w_busy  = 1'b1;
        w_we    = 1'b1;
        w_wsq   = idx_q;
        w_wdata = init_piece(idx_q);
        idx_d   = idx_q + 6'd1;
        if (idx_q == 6'd63) state_d = ST_IDLE;
      end
      default: begin
        w_we = bus.wr_en;
        if (bus.load_req) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 64; i++) board_q[i] <= 4'h0;
    end else if (w_we) begin
      board_q[w_wsq] <= w_wdata;
    end
  end

  assign bus.busy     = w_busy;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.rd_piece = board_q[bus.rd_sq];

  // S0: board-relative offsets split into square index and in-square pixel.
  logic [9:0]  w_xo, w_yo, w_px, w_py;
  logic [2:0]  w_col, w_row;
  logic [11:0] w_off;
  logic        w_inside;

  always_comb begin
    w_xo  = bus.DrawX - X_LO[9:0];
    w_yo  = bus.DrawY - Y_LO[9:0];
    w_col = '0;
    w_row = '0;
    for (int t = 1; t < 8; t++) begin
      if (w_xo >= 10'(t * SQ_PIX)) w_col = w_col + 3'd1;
      if (w_yo >= 10'(t * SQ_PIX)) w_row = w_row + 3'd1;
    end
    w_px     = w_xo - 10'(w_col) * 10'(SQ_PIX);
    w_py     = w_yo - 10'(w_row) * 10'(SQ_PIX);
    w_off    = 12'(w_py) * 12'(SQ_PIX) + 12'(w_px);
    w_inside = ({1'b0, bus.DrawX} >= X_LO) && ({1'b0, bus.DrawX} < X_HI) &&
               ({1'b0, bus.DrawY} >= Y_LO) && ({1'b0, bus.DrawY} < Y_HI);
  end

  logic [5:0]  s1_sq_q;
  logic [11:0] s1_off_q;
  logic        s1_light_q, s1_in_q, s1_v_q;
  logic [16:0] sprite_addr_q;
  logic        addr_valid_q, in_board_q, in_board_ram_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_sq_q        <= '0;
      s1_off_q       <= '0;
      s1_light_q     <= 1'b0;
      s1_in_q        <= 1'b0;
      s1_v_q         <= 1'b0;
      sprite_addr_q  <= '0;
      addr_valid_q   <= 1'b0;
      in_board_q     <= 1'b0;
      in_board_ram_q <= 1'b0;
    end else begin
      s1_v_q <= bus.pix_en;
      if (bus.pix_en) begin
        s1_sq_q    <= {w_row, w_col};
        s1_off_q   <= w_off;
        s1_light_q <= ~(w_row[0] ^ w_col[0]);
        s1_in_q    <= w_inside;
      end
      // Board read sees the pre-write value on a same-cycle write.
      if (s1_v_q)
        sprite_addr_q <= s1_in_q ? {s1_light_q, board_q[s1_sq_q], s1_off_q} : 17'h0;
      addr_valid_q   <= s1_v_q;
      in_board_q     <= s1_v_q & s1_in_q;
      in_board_ram_q <= in_board_q;
    end
  end

  assign bus.sprite_addr  = sprite_addr_q;
  assign bus.addr_valid   = addr_valid_q;
  assign bus.in_board     = in_board_q;
  assign bus.in_board_ram = in_board_ram_q;

endmodule
`default_nettype wire

// File: tb/tb_chess_sprite_addr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_chess_sprite_addr_ctrl : directed bench for chess_sprite_addr_ctrl
// Revision: 1.0
// ============================================================================
module tb_chess_sprite_addr_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;

  always #5 clk = ~clk;

  chess_sprite_addr_ctrl_if bus ();

  chess_sprite_addr_ctrl #(
    .BOARD_X0(80),
    .BOARD_Y0(0),
    .SQ_PIX  (60)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting position written out by hand from the board layout.
  function automatic logic [3:0] exp_init(input int sq);
    logic [3:0] r0 [8];
    logic [3:0] r7 [8];
    r0 = '{4'h4, 4'h3, 4'h2, 4'h5, 4'h6, 4'h2, 4'h3, 4'h4};
    r7 = '{4'hC, 4'hB, 4'hA, 4'hD, 4'hE, 4'hA, 4'hB, 4'hC};
    case (sq / 8)
      0:       exp_init = r0[sq % 8];
      1:       exp_init = 4'h1;
      6:       exp_init = 4'h9;
      7:       exp_init = r7[sq % 8];
      default: exp_init = 4'h0;
    endcase
  endfunction

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) break;
      cnt++;
      tick();
    end
  endtask

  task automatic check_table();
    for (int s = 0; s < 64; s++) begin
      bus.rd_sq = 6'(s);
      #0.1;
      check($sformatf("init_sq%0d", s), 32'(bus.rd_piece), 32'(exp_init(s)));
    end
  endtask

  // One accepted pixel; leaves time just after sprite_addr registers.
  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    bus.pix_en = 1'b1;
    bus.DrawX  = x;
    bus.DrawY  = y;
    tick();
    bus.pix_en = 1'b0;
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    bus.pix_en   = 1'b0;
    bus.DrawX    = '0;
    bus.DrawY    = '0;
    bus.wr_en    = 1'b0;
    bus.wr_sq    = '0;
    bus.wr_piece = '0;
    bus.load_req = 1'b0;
    bus.rd_sq    = '0;
    #2;
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_sprite_addr", 32'(bus.sprite_addr), 32'd0);
    check("rst_addr_valid", 32'(bus.addr_valid), 32'd0);
    check("rst_in_board", 32'(bus.in_board), 32'd0);
    check("rst_in_board_ram", 32'(bus.in_board_ram), 32'd0);
    check("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    check("rst_rd_piece", 32'(bus.rd_piece), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    count_busy(n);
    check("load_busy_cycles", 32'(n), 32'd64);
    bus.rd_sq = 6'd4;  #0.1; check("rd_sq4", 32'(bus.rd_piece), 32'h6);
    bus.rd_sq = 6'd60; #0.1; check("rd_sq60", 32'(bus.rd_piece), 32'hE);
    bus.rd_sq = 6'd27; #0.1; check("rd_sq27", 32'(bus.rd_piece), 32'h0);
    bus.rd_sq = 6'd48; #0.1; check("rd_sq48", 32'(bus.rd_piece), 32'h9);

    // Render path
    pix(10'd80, 10'd0);
    check("p80_0_addr", 32'(bus.sprite_addr), 32'h14000);
    check("p80_0_valid", 32'(bus.addr_valid), 32'd1);
    check("p80_0_inb", 32'(bus.in_board), 32'd1);
    check("p80_0_ram_early", 32'(bus.in_board_ram), 32'd0);
    tick();
    check("p80_0_ram", 32'(bus.in_board_ram), 32'd1);
    check("p80_0_valid_drop", 32'(bus.addr_valid), 32'd0);
    pix(10'd141, 10'd1);
    check("p141_1_addr", 32'(bus.sprite_addr), 32'h0303D);
    pix(10'd140, 10'd60);
    check("p140_60_addr", 32'(bus.sprite_addr), 32'h11000);
    pix(10'd559, 10'd479);
    check("p559_479_addr", 32'(bus.sprite_addr), 32'h1CE0F);
    pix(10'd79, 10'd0);
    check("p79_addr", 32'(bus.sprite_addr), 32'h0);
    check("p79_inb", 32'(bus.in_board), 32'd0);
    check("p79_valid", 32'(bus.addr_valid), 32'd1);
    pix(10'd559, 10'd479);
    pix(10'd560, 10'd0);
    check("p560_addr", 32'(bus.sprite_addr), 32'h0);
    check("p560_inb", 32'(bus.in_board), 32'd0);
    check("p560_valid", 32'(bus.addr_valid), 32'd1);
    pix(10'd559, 10'd479);
    tick(); tick(); tick();
    check("hold_valid", 32'(bus.addr_valid), 32'd0);
    check("hold_addr", 32'(bus.sprite_addr), 32'h1CE0F);

    // Game-logic write in IDLE
    bus.wr_en = 1'b1; bus.wr_sq = 6'd27; bus.wr_piece = 4'd5;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_sq = 6'd27;
    #0.1;
    check("idle_wr_ack", 32'(bus.wr_ack), 32'd1);
    check("idle_wr_data", 32'(bus.rd_piece), 32'h5);
    pix(10'd260, 10'd180);
    check("p_sq27_addr", 32'(bus.sprite_addr), 32'h15000);
    check("wr_ack_pulse", 32'(bus.wr_ack), 32'd0);

    // Reload; a write during LOAD is dropped
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    check("reload_busy", 32'(bus.busy), 32'd1);
    repeat (40) tick();
    bus.wr_en = 1'b1; bus.wr_sq = 6'd27; bus.wr_piece = 4'd5;
    bus.load_req = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.load_req = 1'b0;
    check("load_wr_ack", 32'(bus.wr_ack), 32'd0);
    count_busy(n);
    check("reload_rest_cycles", 32'(n), 32'd23);
    bus.rd_sq = 6'd27; #0.1;
    check("reload_sq27", 32'(bus.rd_piece), 32'h0);

    // Reset in the middle of LOAD
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    repeat (30) tick();
    bus.pix_en = 1'b1; bus.DrawX = 10'd80; bus.DrawY = 10'd0;
    tick();
    bus.pix_en = 1'b0;
    rst = 1'b1;
    #1;
    bus.rd_sq = 6'd4;  #0.1; check("mid_rst_sq4", 32'(bus.rd_piece), 32'h0);
    bus.rd_sq = 6'd60; #0.1; check("mid_rst_sq60", 32'(bus.rd_piece), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'd1);
    tick();
    check("mid_rst_valid", 32'(bus.addr_valid), 32'd0);
    check("mid_rst_inb", 32'(bus.in_board), 32'd0);
    tick();
    rst = 1'b0;
    count_busy(n);
    check("post_rst_busy_cycles", 32'(n), 32'd64);
    check_table();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
